// File: rtl/ras_pkg.sv
// Shared types and helpers for the multi-port return-address-stack RAM.
// Holds the sweep FSM state encoding and the per-entry init value rule.
package ras_pkg;

  typedef enum logic {INIT, IDLE} ras_bram_st_e;

  // Entry i after a sweep: OFS + i*INCR, truncated to the storage width.
  function automatic logic [63:0] ras_init_val(input logic [63:0] i, input logic [63:0] ofs,
                                               input logic [63:0] incr, input int unsigned width);
    logic [63:0] v;
    v = ofs + i * incr;
    if (width < 64) v = v & ((64'd1 << width) - 64'd1);
    return v;
  endfunction

endpackage

// File: rtl/ras_bram_rdport.sv
// One read port: same-cycle write bypass, out-of-range masking and a
// latency-1 or latency-2 data/valid pipeline.
module ras_bram_rdport #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned WIDTH     = 36,
  parameter int unsigned ADDR      = 10,
  parameter bit          OUT_REG   = 1'b0,
  parameter bit          WR_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [ADDR-1:0]  addr_i,
  input  logic [WIDTH-1:0] mem_i,
  input  logic             we_a_i,
  input  logic [ADDR-1:0]  waddra_i,
  input  logic [WIDTH-1:0] wia_i,
  input  logic             we_b_i,
  input  logic [ADDR-1:0]  waddrb_i,
  input  logic [WIDTH-1:0] wib_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dvalid_o
);

  localparam int STAGES = OUT_REG ? 1 : 0;

  logic [WIDTH-1:0]             rdata;
  logic [STAGES:0]              vld_pipe_q;
  logic [STAGES:0][WIDTH-1:0]   dat_pipe_q;

  // Write enables arrive already qualified, so A wins a same-address tie upstream.
  always_comb begin
    rdata = mem_i;
    if (WR_BYPASS && we_a_i && (waddra_i == addr_i))      rdata = wia_i;
    else if (WR_BYPASS && we_b_i && (waddrb_i == addr_i)) rdata = wib_i;
    if (32'(addr_i) >= DEPTH) rdata = '0;
  end

  // Data registers only load on a valid so dout holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= en_i;
      if (en_i) dat_pipe_q[0] <= rdata;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        if (vld_pipe_q[s-1]) dat_pipe_q[s] <= dat_pipe_q[s-1];
      end
    end
  end

  assign dout_o   = dat_pipe_q[STAGES];
  assign dvalid_o = vld_pipe_q[STAGES];

endmodule

// File: rtl/ras_bram_mp.sv
// Return-address-stack storage: NRD read ports, two write ports, collision
// flag, and a post-reset / on-request sweep loading OFS + i*INCR into every entry.
module ras_bram_mp
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned WIDTH     = 36,
  parameter int unsigned NRD       = 2,
  parameter logic [63:0] OFS       = 64'd0,
  parameter logic [63:0] INCR      = 64'd0,
  parameter bit          OUT_REG   = 1'b0,
  parameter bit          WR_BYPASS = 1'b1,
  localparam int unsigned ADDR     = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_req,
  output logic                       busy,
  input  logic                       wea,
  input  logic [ADDR-1:0]            waddra,
  input  logic [WIDTH-1:0]           wia,
  input  logic                       web,
  input  logic [ADDR-1:0]            waddrb,
  input  logic [WIDTH-1:0]           wib,
  input  logic [NRD-1:0]             re,
  input  logic [NRD-1:0][ADDR-1:0]   raddr,
  output logic [NRD-1:0][WIDTH-1:0]  dout,
  output logic [NRD-1:0]             dvalid,
  output logic                       wcollide
);

  localparam logic [ADDR-1:0]  LAST  = ADDR'(DEPTH - 1);
  localparam logic [WIDTH-1:0] INIT0 = WIDTH'(ras_init_val(64'd0, OFS, INCR, WIDTH));
  localparam logic [WIDTH-1:0] STEP  = WIDTH'(INCR);

  ras_bram_st_e     st_q, st_d;
  logic [ADDR-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] ival_q, ival_d;
  logic             wcollide_q, wcollide_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic idle, a_ok, b_ok, same_addr, we_a, we_b;

  assign idle      = (st_q == IDLE);
  assign a_ok      = (32'(waddra) < DEPTH);
  assign b_ok      = (32'(waddrb) < DEPTH);
  assign same_addr = (waddra == waddrb);
  assign we_a      = idle & wea & a_ok;
  assign we_b      = idle & web & b_ok & ~(wea & same_addr);
  assign wcollide_d = idle & wea & web & same_addr;

  // The init value is accumulated rather than multiplied out per entry.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    ival_d = ival_q;
    case (st_q)
      INIT: begin
        cnt_d  = cnt_q + 1'b1;
        ival_d = ival_q + STEP;
        if (cnt_q == LAST) st_d = IDLE;
      end
      IDLE: begin
        if (init_req) begin
          st_d   = INIT;
          cnt_d  = '0;
          ival_d = INIT0;
        end
      end
      default: st_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= INIT;
      cnt_q      <= '0;
      ival_q     <= INIT0;
      wcollide_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      ival_q     <= ival_d;
      wcollide_q <= wcollide_d;
    end
  end

  // Storage has no reset; the sweep is what gives it defined contents.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[cnt_q] <= ival_q;
    end else begin
      if (we_a) mem[waddra] <= wia;
      if (we_b) mem[waddrb] <= wib;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    ras_bram_rdport #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR(ADDR), .OUT_REG(OUT_REG), .WR_BYPASS(WR_BYPASS)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .en_i     (idle & re[g]),
      .addr_i   (raddr[g]),
      .mem_i    (mem[raddr[g]]),
      .we_a_i   (we_a),
      .waddra_i (waddra),
      .wia_i    (wia),
      .we_b_i   (we_b),
      .waddrb_i (waddrb),
      .wib_i    (wib),
      .dout_o   (dout[g]),
      .dvalid_o (dvalid[g])
    );
  end

  assign busy     = (st_q == INIT);
  assign wcollide = wcollide_q;

endmodule

// File: tb/tb_ras_bram_mp.sv
// Bench for ras_bram_mp: two instances sharing inputs (16-deep/bypass/latency-1
// and 12-deep/no-bypass/latency-2) checked against a cycle-level reference model.
module tb_ras_bram_mp;

  localparam int W  = 36;
  localparam int A  = 4;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst, init_req, wea, web;
  logic [A-1:0]          waddra, waddrb;
  logic [W-1:0]          wia, wib;
  logic [NR-1:0]         re;
  logic [NR-1:0][A-1:0]  raddr;

  logic [1:0]                   busy_w, wc_w;
  logic [1:0][NR-1:0]           dv_w;
  logic [1:0][NR-1:0][W-1:0]    do_w;

  always #5 clk = ~clk;

  ras_bram_mp #(.DEPTH(16), .WIDTH(W), .NRD(NR), .OFS(64'h100), .INCR(64'd4),
                .OUT_REG(1'b0), .WR_BYPASS(1'b1)) u0 (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy_w[0]),
    .wea(wea), .waddra(waddra), .wia(wia), .web(web), .waddrb(waddrb), .wib(wib),
    .re(re), .raddr(raddr), .dout(do_w[0]), .dvalid(dv_w[0]), .wcollide(wc_w[0]));

  ras_bram_mp #(.DEPTH(12), .WIDTH(W), .NRD(NR), .OFS(64'h100), .INCR(64'd4),
                .OUT_REG(1'b1), .WR_BYPASS(1'b0)) u1 (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy_w[1]),
    .wea(wea), .waddra(waddra), .wia(wia), .web(web), .waddrb(waddrb), .wib(wib),
    .re(re), .raddr(raddr), .dout(do_w[1]), .dvalid(dv_w[1]), .wcollide(wc_w[1]));

  int checks, errors, ncyc;

  // ---------------- reference model ----------------
  logic [W-1:0] mm   [2][16];
  int           bl   [2];          // sweep cycles still to run
  logic         ev   [2][NR][4];   // read results keyed by the edge they appear after
  logic [W-1:0] edat [2][NR][4];
  logic         xb [2], xwc [2];
  logic [NR-1:0] xv [2];
  logic [W-1:0] xd [2][NR];

  function automatic int dep(int k);  return (k == 0) ? 16 : 12; endfunction
  function automatic int lat(int k);  return (k == 0) ? 0 : 1;   endfunction
  function automatic bit byp(int k);  return (k == 0);           endfunction
  function automatic logic [W-1:0] initv(int i); return W'(64'h100 + 64'(i) * 64'd4); endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      bl[k] = dep(k); xb[k] = 1'b1; xwc[k] = 1'b0; xv[k] = '0;
      for (int p = 0; p < NR; p++) begin
        xd[k][p] = '0;
        for (int s = 0; s < 4; s++) begin ev[k][p][s] = 1'b0; edat[k][p][s] = '0; end
      end
    end
  endtask

  task automatic model_edge();
    int n;
    n = ncyc + 1;
    for (int k = 0; k < 2; k++) begin
      int d;
      d = dep(k);
      if (bl[k] > 0) begin
        for (int p = 0; p < NR; p++) ev[k][p][(n + lat(k)) % 4] = 1'b0;
        bl[k]--;
        if (bl[k] == 0) for (int i = 0; i < d; i++) mm[k][i] = initv(i);
        xwc[k] = 1'b0;
      end else begin
        for (int p = 0; p < NR; p++) begin
          logic [W-1:0] v;
          v = '0;
          if (re[p]) begin
            if (int'(raddr[p]) >= d)                         v = '0;
            else if (byp(k) && wea && waddra == raddr[p])    v = wia;
            else if (byp(k) && web && waddrb == raddr[p])    v = wib;
            else                                             v = mm[k][raddr[p]];
          end
          ev[k][p][(n + lat(k)) % 4]   = re[p];
          edat[k][p][(n + lat(k)) % 4] = v;
        end
        xwc[k] = wea && web && (waddra == waddrb);
        if (wea && int'(waddra) < d) mm[k][waddra] = wia;
        if (web && int'(waddrb) < d && !(wea && waddra == waddrb)) mm[k][waddrb] = wib;
        if (init_req) bl[k] = d;
      end
      xb[k] = (bl[k] > 0);
      for (int p = 0; p < NR; p++) begin
        xv[k][p] = ev[k][p][n % 4];
        if (ev[k][p][n % 4]) xd[k][p] = edat[k][p][n % 4];
        ev[k][p][n % 4] = 1'b0;
      end
    end
    ncyc = n;
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.busy", k), 64'(busy_w[k]), 64'(xb[k]));
      chk($sformatf("u%0d.wcollide", k), 64'(wc_w[k]), 64'(xwc[k]));
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("u%0d.dvalid[%0d]", k, p), 64'(dv_w[k][p]), 64'(xv[k][p]));
        chk($sformatf("u%0d.dout[%0d]", k, p), 64'(do_w[k][p]), 64'(xd[k][p]));
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle_in();
    wea = 1'b0; web = 1'b0; re = '0; init_req = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    model_reset();
    #1;
    model_check();
    repeat (hold) begin @(posedge clk); #1; model_check(); end
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy_w != 2'b00 && n < budget) begin tick(); n++; end
    chk("wait_idle", 64'(busy_w), 64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] re; logic [3:0] a0, a1;
    logic wea; logic [3:0] wa; logic [W-1:0] wd;
    logic web; logic [3:0] wb; logic [W-1:0] wbd;
    logic [1:0] xv; logic [W-1:0] x0, x1;
  } vec_t;

  function automatic vec_t mkv(logic [1:0] r, logic [3:0] a0, logic [3:0] a1,
                               logic ea, logic [3:0] wa, logic [W-1:0] wd,
                               logic eb, logic [3:0] wb, logic [W-1:0] wbd,
                               logic [1:0] xv, logic [W-1:0] x0, logic [W-1:0] x1);
    vec_t v;
    v.re = r; v.a0 = a0; v.a1 = a1; v.wea = ea; v.wa = wa; v.wd = wd;
    v.web = eb; v.wb = wb; v.wbd = wbd; v.xv = xv; v.x0 = x0; v.x1 = x1;
    return v;
  endfunction

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] r64;
    tbl[0] = mkv(2'b11, 4'd0, 4'd15, 0, 0, 0,         0, 0, 0,        2'b11, 36'h100, 36'h13C);
    tbl[1] = mkv(2'b01, 4'd3, 4'd0,  1, 3, 36'hABC,   0, 0, 0,        2'b01, 36'hABC, 36'h13C);
    tbl[2] = mkv(2'b10, 4'd0, 4'd3,  0, 0, 0,         0, 0, 0,        2'b10, 36'hABC, 36'hABC);
    tbl[3] = mkv(2'b00, 4'd0, 4'd0,  0, 0, 0,         0, 0, 0,        2'b00, 36'hABC, 36'hABC);
    tbl[4] = mkv(2'b11, 4'd7, 4'd7,  0, 0, 0,         0, 0, 0,        2'b11, 36'h11C, 36'h11C);
    tbl[5] = mkv(2'b01, 4'd8, 4'd0,  0, 0, 0,         1, 8, 36'h55,   2'b01, 36'h55,  36'h11C);
    tbl[6] = mkv(2'b11, 4'd3, 4'd8,  0, 0, 0,         0, 0, 0,        2'b11, 36'hABC, 36'h55);
    tbl[7] = mkv(2'b11, 4'd5, 4'd6,  1, 5, 36'h99,    1, 6, 36'h66,   2'b11, 36'h99,  36'h66);

    checks = 0; errors = 0; ncyc = 0;
    rst = 1'b1; idle_in();
    waddra = '0; waddrb = '0; wia = '0; wib = '0; raddr = '0;
    do_reset(2);

    // Sweep length after reset, then every entry holds its init value.
    n = 0;
    while (busy_w[0] && n < 100) begin tick(); n++; end
    chk("sweep_len", 64'(n), 64'd16);
    for (int i = 0; i < 16; i++) begin
      re = 2'b11; raddr[0] = 4'(i); raddr[1] = 4'(15 - i);
      tick();
      chk("init_rd", 64'(do_w[0][0]), 64'h100 + 64'(i) * 4);
    end
    idle_in(); tick(); tick();

    for (int i = 0; i < 8; i++) begin
      re = tbl[i].re; raddr[0] = tbl[i].a0; raddr[1] = tbl[i].a1;
      wea = tbl[i].wea; waddra = tbl[i].wa; wia = tbl[i].wd;
      web = tbl[i].web; waddrb = tbl[i].wb; wib = tbl[i].wbd;
      tick();
      chk($sformatf("tbl%0d.dvalid", i), 64'(dv_w[0]), 64'(tbl[i].xv));
      chk($sformatf("tbl%0d.dout0", i), 64'(do_w[0][0]), 64'(tbl[i].x0));
      chk($sformatf("tbl%0d.dout1", i), 64'(do_w[0][1]), 64'(tbl[i].x1));
    end
    idle_in(); tick(); tick();

    // Write collision: A wins, flag is a single-cycle pulse.
    wea = 1; waddra = 5; wia = 36'h11; web = 1; waddrb = 5; wib = 36'h22;
    tick();
    chk("coll_pulse", 64'(wc_w), 64'b11);
    idle_in(); tick();
    chk("coll_clear", 64'(wc_w), 64'b00);
    re = 2'b01; raddr[0] = 5; tick();
    chk("coll_rd_u0", 64'(do_w[0][0]), 64'h11);
    idle_in(); tick();
    chk("coll_rd_u1", 64'(do_w[1][0]), 64'h11);

    // Same-cycle read/write: bypass instance sees new data, other sees old.
    wea = 1; waddra = 3; wia = 36'h777; re = 2'b01; raddr[0] = 3;
    tick();
    chk("byp_new", 64'(do_w[0][0]), 64'h777);
    idle_in(); tick();
    chk("nobyp_old", 64'(do_w[1][0]), 64'hABC);
    tick();

    // Back-to-back reads through the output register: no bubbles.
    re = 2'b11; raddr[0] = 1; raddr[1] = 1; tick();
    chk("b2b_t1", 64'(dv_w[1]), 64'b00);
    raddr[0] = 2; raddr[1] = 2; tick();
    chk("b2b_t2v", 64'(dv_w[1]), 64'b11);
    chk("b2b_t2d", 64'(do_w[1][1]), 64'h104);
    idle_in(); tick();
    chk("b2b_t3v", 64'(dv_w[1]), 64'b11);
    chk("b2b_t3d", 64'(do_w[1][0]), 64'h108);
    tick();
    chk("b2b_t4v", 64'(dv_w[1]), 64'b00);

    // Out-of-range read on the 12-deep instance returns 0 but is valid.
    re = 2'b01; raddr[0] = 13; tick();
    chk("oor_u0", 64'(do_w[0][0]), 64'h134);
    idle_in(); tick();
    chk("oor_u1v", 64'(dv_w[1][0]), 64'd1);
    chk("oor_u1d", 64'(do_w[1][0]), 64'd0);
    tick();

    // Re-init after a write; an in-flight read completes with old data; busy writes dropped.
    wea = 1; waddra = 9; wia = 36'hFFF; tick();
    idle_in(); init_req = 1; re = 2'b01; raddr[0] = 9; tick();
    chk("reinit_busy", 64'(busy_w), 64'b11);
    init_req = 0; wea = 1; waddra = 9; wia = 36'h123; re = 2'b11; raddr[1] = 9;
    tick();
    chk("inflight_v", 64'(dv_w[1][0]), 64'd1);
    chk("inflight_d", 64'(do_w[1][0]), 64'hFFF);
    repeat (9) tick();
    idle_in();
    wait_idle(100);
    re = 2'b01; raddr[0] = 9; tick();
    chk("reinit_u0", 64'(do_w[0][0]), 64'h124);
    idle_in(); tick();
    chk("reinit_u1", 64'(do_w[1][0]), 64'h124);

    // Reset with reads in flight, then reset again mid-sweep.
    re = 2'b11; raddr[0] = 0; raddr[1] = 0; tick();
    idle_in();
    do_reset(2);
    chk("rst_dvalid", 64'(dv_w), 64'd0);
    repeat (7) tick();
    do_reset(1);
    n = 0;
    while (busy_w[0] && n < 100) begin tick(); n++; end
    chk("restart_len", 64'(n), 64'd16);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      re = NR'($urandom);
      raddr[0] = A'($urandom); raddr[1] = A'($urandom);
      wea = 1'($urandom); web = 1'($urandom);
      waddra = A'($urandom);
      waddrb = ($urandom_range(0, 3) == 0) ? waddra : A'($urandom);
      r64 = {$urandom, $urandom}; wia = W'(r64);
      r64 = {$urandom, $urandom}; wib = W'(r64);
      init_req = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 499) == 0) do_reset(1);
      else tick();
    end
    idle_in(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
